fsm_escribir_rtc: RTL

Write sequencer for the external RTC's multiplexed parallel bus; the counterpart of the read sequencer. On a start pulse it walks a fixed list of RTC registers and, for each, issues an address phase then a data phase carrying the value selected from the local time/date/timer register file. It finishes with a command-only phase (0xF1) that transfers the written values into the RTC counters. It sits between the user-side register file and the RTC pins, sharing the bus with the read sequencer through the top-level pin mux.

---
 rtl/rtc_escr_pkg.sv | 68 ++++++
 rtl/rtc_bus_phase.sv | 110 +++++++++++
 rtl/fsm_escribir_rtc.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rtc_escr_pkg.sv
// rtc_escr_pkg
// Shared constants and types for the RTC write sequencer: RTC register
// addresses, the transfer command byte, default bus timing, the entry count
// and the state encodings of the top FSM and of the bus-phase engine.
// Build option: ESCR_TIMER_EN adds the three timer registers (entries 6-8)
// to the write list.
package rtc_escr_pkg;

    localparam int T_SETUP_DEF  = 2;
    localparam int T_STROBE_DEF = 4;
    localparam int T_HOLD_DEF   = 2;

    localparam logic [7:0] ADDR_SEG      = 8'h21;
    localparam logic [7:0] ADDR_MIN      = 8'h22;
    localparam logic [7:0] ADDR_HORA     = 8'h23;
    localparam logic [7:0] ADDR_DIA      = 8'h24;
    localparam logic [7:0] ADDR_MES      = 8'h25;
    localparam logic [7:0] ADDR_ANIO     = 8'h26;
    localparam logic [7:0] ADDR_SEG_TIM  = 8'h41;
    localparam logic [7:0] ADDR_MIN_TIM  = 8'h42;
    localparam logic [7:0] ADDR_HORA_TIM = 8'h43;

    // Copies the written holding registers into the RTC counters.
    localparam logic [7:0] CMD_TRANSFER  = 8'hF1;

`ifdef ESCR_TIMER_EN
    localparam int N_ENTRIES = 9;
`else
    localparam int N_ENTRIES = 6;
`endif

    localparam logic [3:0] LAST_ENTRY = 4'(N_ENTRIES - 1);
    localparam logic [3:0] SEL_CMD    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CMD,
        ST_FIN
    } escr_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD,
        PH_GAP
    } phase_state_t;

    function automatic logic [7:0] entry_addr(input logic [3:0] idx);
        logic [7:0] addr;
        case (idx)
            4'd0:    addr = ADDR_SEG;
            4'd1:    addr = ADDR_MIN;
            4'd2:    addr = ADDR_HORA;
            4'd3:    addr = ADDR_DIA;
            4'd4:    addr = ADDR_MES;
            4'd5:    addr = ADDR_ANIO;
            4'd6:    addr = ADDR_SEG_TIM;
            4'd7:    addr = ADDR_MIN_TIM;
            4'd8:    addr = ADDR_HORA_TIM;
            default: addr = 8'h00;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// rtc_bus_phase
// Runs one RTC bus phase: SETUP (T_SETUP) / STROBE (T_STROBE) / HOLD (T_HOLD)
// / GAP (1), i.e. T_SETUP+T_STROBE+T_HOLD+1 cycles. a_d and the bus byte are
// captured on go and held for the whole phase, GAP included. A go seen in the
// GAP cycle chains straight into the next phase with no idle cycle.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   go             start a phase (accepted in idle or in GAP)
//   a_d_in, byte_in  address/data select and bus byte for the phase
//   cs, wr         RTC chip select / write strobe, active low
//   a_d, bus_out   held phase values
//   bus_oe         tristate enable, high while cs is low
//   phase_done     high in the GAP cycle
//
// state     | meaning
// PH_IDLE   | no phase, bus released, a_d=1, bus_out=0
// PH_SETUP  | cs low, bus driven, wr high
// PH_STROBE | cs low, wr low
// PH_HOLD   | cs low, wr high, bus still driven
// PH_GAP    | cs high, bus released, phase_done
module rtc_bus_phase
    import rtc_escr_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       a_d_in,
    input  logic [7:0] byte_in,
    output logic       cs,
    output logic       wr,
    output logic       a_d,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       phase_done
);

    localparam int P     = T_SETUP + T_STROBE + T_HOLD + 1;
    localparam int CNT_W = $clog2(P);

    phase_state_t      p_state, p_next;
    logic [CNT_W-1:0]  cnt;
    logic              a_d_q;
    logic [7:0]        bus_q;
    logic              load;

    assign load = go && (p_state == PH_IDLE || p_state == PH_GAP);

    // State register, sub-phase down-counter and held phase values.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_state <= PH_IDLE;
            cnt     <= '0;
            a_d_q   <= 1'b1;
            bus_q   <= 8'h00;
        end else begin
            p_state <= p_next;
            if (p_next != p_state) begin
                case (p_next)
                    PH_SETUP:  cnt <= CNT_W'(T_SETUP - 1);
                    PH_STROBE: cnt <= CNT_W'(T_STROBE - 1);
                    PH_HOLD:   cnt <= CNT_W'(T_HOLD - 1);
                    default:   cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (load) begin
                a_d_q <= a_d_in;
                bus_q <= byte_in;
            end else if (p_state == PH_GAP) begin
                a_d_q <= 1'b1;
                bus_q <= 8'h00;
            end
        end
    end

    always_comb begin
        p_next = p_state;
        case (p_state)
            PH_IDLE:   if (go) p_next = PH_SETUP;
            PH_SETUP:  if (cnt == '0) p_next = PH_STROBE;
            PH_STROBE: if (cnt == '0) p_next = PH_HOLD;
            PH_HOLD:   if (cnt == '0) p_next = PH_GAP;
            PH_GAP:    p_next = go ? PH_SETUP : PH_IDLE;
            default:   p_next = PH_IDLE;
        endcase
    end

    always_comb begin
        cs         = 1'b1;
        wr         = 1'b1;
        bus_oe     = 1'b0;
        phase_done = 1'b0;
        case (p_state)
            PH_SETUP:  begin cs = 1'b0; bus_oe = 1'b1; end
            PH_STROBE: begin cs = 1'b0; wr = 1'b0; bus_oe = 1'b1; end
            PH_HOLD:   begin cs = 1'b0; bus_oe = 1'b1; end
            PH_GAP:    phase_done = 1'b1;
            default:   ;
        endcase
    end

    assign a_d     = a_d_q;
    assign bus_out = bus_q;

endmodule

// File: rtl/fsm_escribir_rtc.sv
// fsm_escribir_rtc
// Write sequencer for the RTC multiplexed bus. On start it writes each entry
// of the register list (address phase, then data phase with the value read
// from the register file at index sel) and ends with the 0xF1 transfer
// command phase. Bus phases are produced by rtc_bus_phase.
// Build option: ESCR_TIMER_EN (defined: 9 entries incl. timer; else 6).
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        one-cycle request, honoured only in IDLE
//   dat_in       register-file value for index sel
//   sel          register-file index (4'hF during the command phase)
//   a_d, cs, rd, wr, bus_out, bus_oe   RTC bus pins (rd held high)
//   busy         sequence in progress
//   done         one-cycle pulse at sequence end
//
// state   | meaning
// ST_IDLE | waiting for start
// ST_ADDR | address phase of entry entry_q
// ST_DATA | data phase of entry entry_q
// ST_CMD  | transfer command phase (0xF1)
// ST_FIN  | one cycle, done pulse
module fsm_escribir_rtc
    import rtc_escr_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dat_in,
    output logic [3:0] sel,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       busy,
    output logic       done
);

    escr_state_t state, state_next;
    logic [3:0]  entry_q;
    logic [3:0]  sel_q;
    logic        go;
    logic        go_a_d;
    logic [7:0]  go_byte;
    logic        phase_done;
    logic        last_entry;

    assign last_entry = (entry_q == LAST_ENTRY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            entry_q <= 4'd0;
            sel_q   <= 4'd0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: if (start) begin
                    entry_q <= 4'd0;
                    sel_q   <= 4'd0;
                end
                ST_DATA: if (phase_done) begin
                    if (last_entry) begin
                        sel_q <= SEL_CMD;
                    end else begin
                        entry_q <= entry_q + 4'd1;
                        sel_q   <= entry_q + 4'd1;
                    end
                end
                ST_CMD: if (phase_done) sel_q <= 4'd0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_ADDR;
            ST_ADDR: if (phase_done) state_next = ST_DATA;
            ST_DATA: if (phase_done) state_next = last_entry ? ST_CMD : ST_ADDR;
            ST_CMD:  if (phase_done) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The next phase is launched in the GAP cycle of the current one so the
    // phases abut. The data byte is captured at the ADDR->DATA boundary,
    // a full phase after sel moved to this entry.
    always_comb begin
        go      = 1'b0;
        go_a_d  = 1'b1;
        go_byte = 8'h00;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                go      = 1'b1;
                go_a_d  = 1'b0;
                go_byte = entry_addr(4'd0);
            end
            ST_ADDR: begin
                busy = 1'b1;
                if (phase_done) begin
                    go      = 1'b1;
                    go_a_d  = 1'b1;
                    go_byte = dat_in;
                end
            end
            ST_DATA: begin
                busy = 1'b1;
                if (phase_done) begin
                    go      = 1'b1;
                    go_a_d  = 1'b0;
                    go_byte = last_entry ? CMD_TRANSFER : entry_addr(entry_q + 4'd1);
                end
            end
            ST_CMD:  busy = 1'b1;
            ST_FIN:  done = 1'b1;
            default: ;
        endcase
    end

    rtc_bus_phase #(
        .T_SETUP  (T_SETUP),
        .T_STROBE (T_STROBE),
        .T_HOLD   (T_HOLD)
    ) u_phase (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .a_d_in     (go_a_d),
        .byte_in    (go_byte),
        .cs         (cs),
        .wr         (wr),
        .a_d        (a_d),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .phase_done (phase_done)
    );

    assign sel = sel_q;
    assign rd  = 1'b1;

endmodule
